bp_fe_fetch_sequencer: RTL and testbench
========================================

BP_FE_FETCH_SEQUENCER -- requirements
Module: bp_fe_fetch_sequencer

Interface
REQ-001 Parameters SHALL be: vaddr_width_p, default 39, virtual PC width; paddr_width_p, default 40, physical address width; instr_width_p, default 32, fetch word width; fifo_els_p, default 4, output buffer depth (power of two, at least 2).
REQ-002 Ports SHALL be:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse to begin fetching.
- start_pc_i  in  vaddr_width_p  first PC, sampled with start_i.
- redirect_v_i  in  1  redirect pulse.
- redirect_pc_i  in  vaddr_width_p  redirect target.
- vaddr_o  out  vaddr_width_p  fetch PC to icache.
- vaddr_v_o  out  1  fetch request valid.
- vaddr_ready_i  in  1  icache accepts the request.
- ptag_o  out  paddr_width_p-12  identity translation of the TL-stage PC.
- ptag_v_o  out  1  TL stage valid.
- uncached_o  out  1  constant 0.
- data_i  in  instr_width_p  icache fetch data.
- data_v_i  in  1  icache hit data valid.
- fetch_pc_o  out  vaddr_width_p  PC at FIFO head.
- fetch_instr_o  out  instr_width_p  instruction at FIFO head.
- fetch_v_o  out  1  FIFO not empty.
- fetch_ready_i  in  1  consumer ready; a transfer occurs when fetch_v_o and fetch_ready_i are both high.

Function
REQ-003 The state machine SHALL have three states: e_idle, e_run and e_replay.
REQ-004 e_idle SHALL go to e_run on start_i, loading next_pc with start_pc_i.
REQ-005 A fetch SHALL be accepted on any cycle where vaddr_v_o and vaddr_ready_i are both high.
REQ-006 vaddr_v_o SHALL be high only in e_run/e_replay, with no redirect this cycle and credits > 0.
REQ-007 Credits SHALL equal fifo_els_p minus (FIFO occupancy + valid TL entries + valid TV entries).
REQ-008 On acceptance, next_pc SHALL become next_pc+4, wrapping modulo 2^vaddr_width_p, and the PC SHALL enter the TL stage.
REQ-009 Each cycle, TL SHALL advance to TV.
REQ-010 ptag_o SHALL be the TL-stage PC bits [vaddr_width_p-1:12], zero-extended.
REQ-011 When TV is valid and data_v_i is high, {pc_tv, data_i} SHALL be pushed into the FIFO in the same cycle.
REQ-012 A hit SHALL reach fetch_v_o 3 cycles after acceptance, given an empty FIFO.
REQ-013 When TV is valid and data_v_i is low (a miss), TL and TV SHALL be invalidated, next_pc SHALL be set to pc_tv, and the state SHALL go to e_replay.
REQ-014 The FIFO SHALL NOT be flushed on a miss.
REQ-015 e_replay SHALL return to e_run when the replayed PC is accepted.
REQ-016 data_v_i with TV invalid SHALL be ignored.
REQ-017 redirect_v_i SHALL invalidate TL, TV and the entire FIFO, and SHALL set next_pc to redirect_pc_i.
REQ-018 redirect_v_i SHALL move e_replay to e_run; in e_idle it SHALL be ignored.
REQ-019 On the redirect cycle, vaddr_v_o SHALL be 0, fetch_v_o SHALL be 0, and a simultaneous data_v_i SHALL be discarded.
REQ-020 Priority SHALL be redirect > miss > normal advance.
REQ-021 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 The FIFO SHALL NOT overflow; credits guarantee this.
REQ-023 start_i outside e_idle SHALL be ignored.

Reset
REQ-024 reset_i SHALL force e_idle, next_pc=0, TL/TV invalid, FIFO empty, and all counters 0.
REQ-025 Out of reset, vaddr_v_o, ptag_v_o, fetch_v_o and uncached_o SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL take effect at the next edge, regardless of in-flight fetches.

Configuration
REQ-027 With macro BP_FE_FETCH_SEQ_STATS_EN defined, the module SHALL add three 32-bit saturating counter outputs: stat_fetch_o (acceptances), stat_miss_o (misses) and stat_redirect_o (redirects), all cleared by reset.
REQ-028 Without BP_FE_FETCH_SEQ_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-029 Scenario: start_pc 0x80000000, all hits, fetch_ready_i=1 -> fetch_pc_o sequence 0x80000000, 0x80000004, ..., with the first fetch_v_o 3 cycles after acceptance and 1 instruction per cycle sustained.
REQ-030 Scenario: miss at 0x80000008 -> TL/TV flushed, 0x80000008 reissued after vaddr_ready_i returns, and the output order is gap-free with no duplicates.
REQ-031 Scenario: fetch_ready_i=0 with fifo_els_p=4 -> vaddr_v_o drops after 4 acceptances, and no FIFO overflow occurs.
REQ-032 Scenario: redirect to 0x80001000 with a full FIFO and TV valid -> fetch_v_o is 0 the next cycle, and the next accepted vaddr_o is 0x80001000.
REQ-033 Scenario: next_pc 0x7FFFFFFFFC at vaddr_width_p=39 -> the following fetch is 0x0.
REQ-034 Scenario: reset asserted during e_replay -> all outputs are 0 the next cycle, and nothing is fetched until start_i.

Source files
------------

// File: rtl/bp_fe_fetch_sequencer_if.sv
// rtl/bp_fe_fetch_sequencer_if.sv - control, icache and fetch-output bundle for bp_fe_fetch_sequencer
interface bp_fe_fetch_sequencer_if #(
    parameter int vaddr_width_p = 39,
    parameter int paddr_width_p = 40,
    parameter int instr_width_p = 32
);
    // Control from the backend
    logic                       start_i;
    logic [vaddr_width_p-1:0]   start_pc_i;
    logic                       redirect_v_i;
    logic [vaddr_width_p-1:0]   redirect_pc_i;

    // Icache request / translation / response
    logic [vaddr_width_p-1:0]   vaddr_o;
    logic                       vaddr_v_o;
    logic                       vaddr_ready_i;
    logic [paddr_width_p-13:0]  ptag_o;
    logic                       ptag_v_o;
    logic                       uncached_o;
    logic [instr_width_p-1:0]   data_i;
    logic                       data_v_i;

    // Fetched instruction stream to the consumer
    logic [vaddr_width_p-1:0]   fetch_pc_o;
    logic [instr_width_p-1:0]   fetch_instr_o;
    logic                       fetch_v_o;
    logic                       fetch_ready_i;

    // The sequencer side
    modport master (
        input  start_i, start_pc_i, redirect_v_i, redirect_pc_i,
        output vaddr_o, vaddr_v_o,
        input  vaddr_ready_i,
        output ptag_o, ptag_v_o, uncached_o,
        input  data_i, data_v_i,
        output fetch_pc_o, fetch_instr_o, fetch_v_o,
        input  fetch_ready_i
    );

    // The environment side (backend, icache, consumer)
    modport slave (
        output start_i, start_pc_i, redirect_v_i, redirect_pc_i,
        input  vaddr_o, vaddr_v_o,
        output vaddr_ready_i,
        input  ptag_o, ptag_v_o, uncached_o,
        output data_i, data_v_i,
        input  fetch_pc_o, fetch_instr_o, fetch_v_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/bp_fe_fetch_sequencer.sv
// rtl/bp_fe_fetch_sequencer.sv - credit-based PC sequencer with TL/TV stages and output FIFO; BP_FE_FETCH_SEQ_STATS_EN adds stat counters
module bp_fe_fetch_sequencer #(
    parameter int vaddr_width_p = 39,
    parameter int paddr_width_p = 40,
    parameter int instr_width_p = 32,
    parameter int fifo_els_p    = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_fe_fetch_sequencer_if.master io
`ifdef BP_FE_FETCH_SEQ_STATS_EN
    ,
    output logic [31:0]             stat_fetch_o,
    output logic [31:0]             stat_miss_o,
    output logic [31:0]             stat_redirect_o
`endif
);

    localparam int ptr_w_lp   = $clog2(fifo_els_p);
    // occupancy plus the two pipeline valids must fit without overflow
    localparam int cnt_w_lp   = ptr_w_lp + 2;
    localparam int entry_w_lp = vaddr_width_p + instr_width_p;
    localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(fifo_els_p);

    typedef enum logic [1:0] {e_idle, e_run, e_replay} state_e;

    state_e                     state_q, state_d;
    logic [vaddr_width_p-1:0]   next_pc_q, next_pc_d;
    logic [vaddr_width_p-1:0]   pc_tl_q, pc_tl_d;
    logic [vaddr_width_p-1:0]   pc_tv_q, pc_tv_d;
    logic                       tl_v_q, tl_v_d;
    logic                       tv_v_q, tv_v_d;

    logic [entry_w_lp-1:0]      mem_q [fifo_els_p];
    logic [entry_w_lp-1:0]      mem_d [fifo_els_p];
    logic [ptr_w_lp-1:0]        rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0]        wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]        count_q, count_d;

    logic                       active;
    logic                       redirect_take;
    logic [cnt_w_lp-1:0]        used;
    logic                       vaddr_v;
    logic                       fetch_v;
    logic                       accept;
    logic                       miss;
    logic                       push;
    logic                       pop;
    logic [paddr_width_p-13:0]  ptag;

    assign active        = (state_q != e_idle);
    assign redirect_take = active & io.redirect_v_i;
    assign used          = count_q + {{(cnt_w_lp-1){1'b0}}, tl_v_q} + {{(cnt_w_lp-1){1'b0}}, tv_v_q};
    assign vaddr_v       = active & ~io.redirect_v_i & (used < els_lp);
    assign fetch_v       = (count_q != '0) & ~io.redirect_v_i;
    assign accept        = vaddr_v & io.vaddr_ready_i;
    assign miss          = tv_v_q & ~io.data_v_i;
    assign push          = tv_v_q & io.data_v_i & ~redirect_take;
    assign pop           = fetch_v & io.fetch_ready_i;

    // Sequencing: redirect beats miss beats normal TL->TV advance
    always_comb begin
        state_d   = state_q;
        next_pc_d = next_pc_q;
        pc_tl_d   = pc_tl_q;
        pc_tv_d   = pc_tv_q;
        tl_v_d    = tl_v_q;
        tv_v_d    = tv_v_q;
        case (state_q)
            e_idle: begin
                if (io.start_i) begin
                    state_d   = e_run;
                    next_pc_d = io.start_pc_i;
                end
            end
            default: begin
                if (redirect_take) begin
                    tl_v_d    = 1'b0;
                    tv_v_d    = 1'b0;
                    next_pc_d = io.redirect_pc_i;
                    state_d   = e_run;
                end else if (miss) begin
                    // any request accepted this cycle is younger than the miss and is dropped
                    tl_v_d    = 1'b0;
                    tv_v_d    = 1'b0;
                    next_pc_d = pc_tv_q;
                    state_d   = e_replay;
                end else begin
                    tv_v_d  = tl_v_q;
                    pc_tv_d = pc_tl_q;
                    tl_v_d  = accept;
                    if (accept) begin
                        pc_tl_d   = next_pc_q;
                        next_pc_d = next_pc_q + vaddr_width_p'(4);
                        if (state_q == e_replay) begin
                            state_d = e_run;
                        end
                    end
                end
            end
        endcase
    end

    // Output FIFO: flushed by redirect, otherwise independent push/pop
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_take) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {pc_tv_q, io.data_i};
                wr_ptr_d        = wr_ptr_q + ptr_w_lp'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_w_lp'(1);
                2'b01:   count_d = count_q - cnt_w_lp'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Physical tag is the identity translation of the TL PC page number
    always_comb begin
        ptag                         = '0;
        ptag[vaddr_width_p-13:0]     = pc_tl_q[vaddr_width_p-1:12];
    end

    // State and FIFO registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            next_pc_q <= '0;
            pc_tl_q   <= '0;
            pc_tv_q   <= '0;
            tl_v_q    <= 1'b0;
            tv_v_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < fifo_els_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            next_pc_q <= next_pc_d;
            pc_tl_q   <= pc_tl_d;
            pc_tv_q   <= pc_tv_d;
            tl_v_q    <= tl_v_d;
            tv_v_q    <= tv_v_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

    assign io.vaddr_o       = next_pc_q;
    assign io.vaddr_v_o     = vaddr_v;
    assign io.ptag_o        = ptag;
    assign io.ptag_v_o      = tl_v_q;
    assign io.uncached_o    = 1'b0;
    assign io.fetch_pc_o    = mem_q[rd_ptr_q][entry_w_lp-1:instr_width_p];
    assign io.fetch_instr_o = mem_q[rd_ptr_q][instr_width_p-1:0];
    assign io.fetch_v_o     = fetch_v;

`ifdef BP_FE_FETCH_SEQ_STATS_EN
    logic [31:0] stat_fetch_q, stat_fetch_d;
    logic [31:0] stat_miss_q, stat_miss_d;
    logic [31:0] stat_redirect_q, stat_redirect_d;

    // Saturating event counters
    always_comb begin
        stat_fetch_d    = stat_fetch_q;
        stat_miss_d     = stat_miss_q;
        stat_redirect_d = stat_redirect_q;
        if (accept && (stat_fetch_q != '1)) begin
            stat_fetch_d = stat_fetch_q + 32'd1;
        end
        if (miss && !redirect_take && (stat_miss_q != '1)) begin
            stat_miss_d = stat_miss_q + 32'd1;
        end
        if (redirect_take && (stat_redirect_q != '1)) begin
            stat_redirect_d = stat_redirect_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_fetch_q    <= '0;
            stat_miss_q     <= '0;
            stat_redirect_q <= '0;
        end else begin
            stat_fetch_q    <= stat_fetch_d;
            stat_miss_q     <= stat_miss_d;
            stat_redirect_q <= stat_redirect_d;
        end
    end

    assign stat_fetch_o    = stat_fetch_q;
    assign stat_miss_o     = stat_miss_q;
    assign stat_redirect_o = stat_redirect_q;
`endif

endmodule

// File: tb/tb_bp_fe_fetch_sequencer.sv
// tb/tb_bp_fe_fetch_sequencer.sv - randomized self-checking bench for bp_fe_fetch_sequencer
module tb_bp_fe_fetch_sequencer;
    localparam int VW  = 39;
    localparam int PW  = 40;
    localparam int IW  = 32;
    localparam int ELS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_fe_fetch_sequencer_if #(.vaddr_width_p(VW), .paddr_width_p(PW), .instr_width_p(IW)) bus ();

`ifdef BP_FE_FETCH_SEQ_STATS_EN
    logic [31:0] stat_fetch, stat_miss, stat_redirect;
`endif

    bp_fe_fetch_sequencer #(
        .vaddr_width_p(VW), .paddr_width_p(PW), .instr_width_p(IW), .fifo_els_p(ELS)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (bus)
`ifdef BP_FE_FETCH_SEQ_STATS_EN
        ,
        .stat_fetch_o    (stat_fetch),
        .stat_miss_o     (stat_miss),
        .stat_redirect_o (stat_redirect)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus knobs (percent, redirect in per-mille)
    int pct_ready, pct_hit, pct_fready, pml_redir, pct_start;
    bit             force_redir;
    logic [VW-1:0]  redir_target;
    bit             miss_armed;
    logic [VW-1:0]  miss_pc;

    // reference model: occupancy bookkeeping and expected PC streams
    bit             running, tl_v, tv_v;
    logic [VW-1:0]  issue_pc, exp_out_pc, tl_pc, tv_pc;
    int             occ;
    int             m_fetch, m_miss, m_redir;

    // observations of the DUT for scenario checks
    int             cyc;
    int             first_acc_cyc, first_fetch_cyc, n_pop_obs;
    logic [VW-1:0]  acc_log [$];
    logic [VW-1:0]  rpc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] instr_of(input logic [VW-1:0] pc);
        return pc[31:0] ^ 32'h5A5A_C3C3 ^ {25'd0, pc[VW-1:32]};
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic clear_obs();
        first_acc_cyc   = -1;
        first_fetch_cyc = -1;
        n_pop_obs       = 0;
        acc_log.delete();
    endtask

    task automatic drive(input bit start, input logic [VW-1:0] spc);
        logic [VW-1:0] r;
        bit hit;
        bus.start_i       = start;
        bus.start_pc_i    = spc;
        bus.vaddr_ready_i = roll(pct_ready);
        bus.fetch_ready_i = roll(pct_fready);
        r                 = {7'd0, $urandom};
        r[1:0]            = 2'b00;
        bus.redirect_v_i  = force_redir || (int'($urandom_range(999)) < pml_redir);
        bus.redirect_pc_i = force_redir ? redir_target : r;
        if (tv_v) begin
            hit = roll(pct_hit);
            if (miss_armed && tv_pc == miss_pc) begin
                hit        = 1'b0;
                miss_armed = 1'b0;
            end
            bus.data_v_i = hit;
            bus.data_i   = instr_of(tv_pc);
        end else begin
            bus.data_v_i = 1'($urandom_range(1));
            bus.data_i   = $urandom;
        end
    endtask

    task automatic tick(input bit start, input logic [VW-1:0] spc);
        bit redir, fr, dv, exp_vv, exp_fv, acc;
        drive(start, spc);
        @(negedge clk);
        redir  = bus.redirect_v_i;
        fr     = bus.fetch_ready_i;
        dv     = bus.data_v_i;
        exp_vv = running && !redir && (occ + int'(tl_v) + int'(tv_v) < ELS);
        exp_fv = (occ > 0) && !redir;
        acc    = exp_vv && bus.vaddr_ready_i;

        check_eq("vaddr_v", bus.vaddr_v_o, exp_vv);
        if (exp_vv) check_eq("vaddr", bus.vaddr_o, issue_pc);
        check_eq("fetch_v", bus.fetch_v_o, exp_fv);
        if (exp_fv) begin
            check_eq("fetch_pc", bus.fetch_pc_o, exp_out_pc);
            check_eq("fetch_instr", bus.fetch_instr_o, instr_of(exp_out_pc));
        end
        check_eq("ptag_v", bus.ptag_v_o, tl_v);
        if (tl_v) check_eq("ptag", bus.ptag_o, 64'(tl_pc >> 12));
        check_eq("uncached", bus.uncached_o, 1'b0);

        if (bus.vaddr_v_o && bus.vaddr_ready_i) begin
            acc_log.push_back(bus.vaddr_o);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (bus.fetch_v_o) begin
            if (first_fetch_cyc < 0) first_fetch_cyc = cyc;
            if (fr) n_pop_obs++;
        end

        if (acc) m_fetch++;
        if (redir && running) begin
            occ        = 0;
            tl_v       = 1'b0;
            tv_v       = 1'b0;
            issue_pc   = bus.redirect_pc_i;
            exp_out_pc = bus.redirect_pc_i;
            m_redir++;
        end else if (running) begin
            if (exp_fv && fr) begin
                occ--;
                exp_out_pc += 4;
            end
            if (tv_v && !dv) begin
                tl_v     = 1'b0;
                tv_v     = 1'b0;
                issue_pc = tv_pc;
                m_miss++;
            end else begin
                if (tv_v) occ++;
                tv_v  = tl_v;
                tv_pc = tl_pc;
                tl_v  = acc;
                if (acc) begin
                    tl_pc    = issue_pc;
                    issue_pc += 4;
                end
            end
        end
        if (start && !running) begin
            running    = 1'b1;
            issue_pc   = spc;
            exp_out_pc = spc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.start_i       = 1'b0;
        bus.start_pc_i    = '0;
        bus.redirect_v_i  = 1'b0;
        bus.redirect_pc_i = '0;
        bus.vaddr_ready_i = 1'b0;
        bus.data_v_i      = 1'b0;
        bus.data_i        = '0;
        bus.fetch_ready_i = 1'b0;
        reset             = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_vaddr_v", bus.vaddr_v_o, 1'b0);
        check_eq("rst_ptag_v", bus.ptag_v_o, 1'b0);
        check_eq("rst_fetch_v", bus.fetch_v_o, 1'b0);
        check_eq("rst_uncached", bus.uncached_o, 1'b0);
        check_eq("rst_vaddr", bus.vaddr_o, 0);
        check_eq("rst_ptag", bus.ptag_o, 0);
        check_eq("rst_fetch_pc", bus.fetch_pc_o, 0);
        check_eq("rst_fetch_instr", bus.fetch_instr_o, 0);
        running = 1'b0; tl_v = 1'b0; tv_v = 1'b0; occ = 0;
        issue_pc = '0; exp_out_pc = '0; tl_pc = '0; tv_pc = '0;
        m_fetch = 0; m_miss = 0; m_redir = 0;
        miss_armed = 1'b0; force_redir = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_knobs(input int r, input int h, input int f, input int rd);
        pct_ready = r; pct_hit = h; pct_fready = f; pml_redir = rd; pct_start = 0;
    endtask

    initial begin
        int dup;
        cyc = 0;
        redir_target = '0; miss_pc = '0;
        set_knobs(100, 100, 100, 0);
        do_reset();

        // streaming with all hits: 3-cycle latency, one instruction per cycle
        clear_obs();
        tick(1'b1, 39'h00_8000_0000);
        repeat (24) tick(1'b0, '0);
        check_eq("stream_latency", 64'(first_fetch_cyc - first_acc_cyc), 3);
        check_eq("stream_pops", n_pop_obs, 21);
        check_eq("stream_first_pc", acc_log[0], 39'h00_8000_0000);

        // single miss at 0x80000008: replayed exactly once, order kept by the model
        do_reset();
        clear_obs();
        miss_pc = 39'h00_8000_0008;
        miss_armed = 1'b1;
        tick(1'b1, 39'h00_8000_0000);
        repeat (20) tick(1'b0, '0);
        dup = 0;
        foreach (acc_log[i]) if (acc_log[i] == miss_pc) dup++;
        check_eq("miss_reissue", dup, 2);

        // consumer stalled: only fifo_els_p acceptances
        do_reset();
        clear_obs();
        set_knobs(100, 100, 0, 0);
        tick(1'b1, 39'h00_8000_0000);
        repeat (12) tick(1'b0, '0);
        check_eq("stall_accepts", acc_log.size(), ELS);
        pct_fready = 100;
        repeat (8) tick(1'b0, '0);

        // redirect with a nearly full FIFO and TV valid
        do_reset();
        set_knobs(100, 100, 0, 0);
        tick(1'b1, 39'h00_8000_0000);
        repeat (5) tick(1'b0, '0);
        force_redir  = 1'b1;
        redir_target = 39'h00_8000_1000;
        tick(1'b0, '0);
        force_redir = 1'b0;
        clear_obs();
        pct_fready = 100;
        repeat (6) tick(1'b0, '0);
        check_eq("redir_first_pc", (acc_log.size() > 0) ? acc_log[0] : '1, 39'h00_8000_1000);

        // PC wraps modulo 2^39
        do_reset();
        clear_obs();
        set_knobs(100, 100, 100, 0);
        tick(1'b1, 39'h7F_FFFF_FFFC);
        repeat (8) tick(1'b0, '0);
        check_eq("wrap_pc0", (acc_log.size() > 1) ? acc_log[0] : '1, 39'h7F_FFFF_FFFC);
        check_eq("wrap_pc1", (acc_log.size() > 1) ? acc_log[1] : '1, 0);

        // reset during replay, then nothing fetched without start
        do_reset();
        set_knobs(100, 0, 100, 0);
        tick(1'b1, 39'h00_8000_0000);
        repeat (3) tick(1'b0, '0);
        do_reset();
        clear_obs();
        set_knobs(100, 100, 100, 0);
        repeat (10) tick(1'b0, '0);
        check_eq("idle_no_fetch", acc_log.size(), 0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                pct_ready  = int'($urandom_range(100, 30));
                pct_hit    = int'($urandom_range(100, 50));
                pct_fready = int'($urandom_range(100, 20));
                pml_redir  = int'($urandom_range(30));
                pct_start  = int'($urandom_range(3));
            end
            rpc = ($urandom_range(7) == 0) ? 39'h7F_FFFF_FFF0 : {7'd0, $urandom};
            rpc[1:0] = 2'b00;
            if (!running) tick(1'b1, rpc);
            else if ($urandom_range(599) == 0) do_reset();
            else tick(roll(pct_start), rpc);
        end
`ifdef BP_FE_FETCH_SEQ_STATS_EN
        check_eq("stat_fetch", stat_fetch, m_fetch);
        check_eq("stat_miss", stat_miss, m_miss);
        check_eq("stat_redirect", stat_redirect, m_redir);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
